// File: rtl/grid_io_cfg_tile.sv
// Perimeter GPIO tile with a double-buffered config chain; optional readback via GRID_IO_CFG_READBACK_EN.
// Latency: shift/commit take effect 1 prog_clk after the edge; the pad datapath is purely combinational.
// Backpressure: none; early commits are rejected and raise the sticky cfg_err flag.
module grid_io_cfg_tile #(
  parameter int NUM_IO   = 8,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              cfg_commit,
  input  logic              cfg_readback,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_A2F,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_F2A,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_DIR
);

  localparam int L  = NUM_IO * CFG_BITS;
  localparam int CW = $clog2(L + 1);

  logic [L-1:0]  sr;
  logic [L-1:0]  act;
  logic [CW-1:0] cnt;

  assign ccff_tail = sr[L-1];
  assign cfg_done  = (cnt == CW'(L));

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr      <= '0;
      act     <= '0;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      // Commit always samples the pre-edge shadow, even while a shift is in flight.
      if (cfg_commit) begin
        if (cfg_done) act <= sr;
        else          cfg_err <= 1'b1;
      end
`ifdef GRID_IO_CFG_READBACK_EN
      if (cfg_readback) begin
        sr  <= act;
        cnt <= '0;
      end else
`endif
      begin
        if (ccff_en) sr <= {sr[L-2:0], ccff_head};
        if (cfg_commit)
          cnt <= ccff_en ? CW'(1) : '0;
        else if (ccff_en && !cfg_done)
          cnt <= cnt + CW'(1);
      end
    end
  end

`ifndef GRID_IO_CFG_READBACK_EN
  logic unused_readback;
  assign unused_readback = cfg_readback ^ (^act);
`endif

  // Subtile word: bit0 = DIR (1 = drive pad), bit1 = INV on the inbound path.
  always_comb begin
    gfpga_pad_GPIO_DIR = '0;
    gfpga_pad_GPIO_F2A = '0;
    io_inpad           = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      gfpga_pad_GPIO_DIR[i] = act[i*CFG_BITS];
      gfpga_pad_GPIO_F2A[i] = act[i*CFG_BITS] & io_outpad[i];
      io_inpad[i]           = ~act[i*CFG_BITS] & (gfpga_pad_GPIO_A2F[i] ^ act[i*CFG_BITS+1]);
    end
  end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// Directed bench for grid_io_cfg_tile (NUM_IO=8, CFG_BITS=2): vector table plus corner-case sequences.
// Latency: n/a. Backpressure: n/a.
module tb_grid_io_cfg_tile;

  logic       prog_clk = 1'b0;
  logic       pReset, ccff_en, ccff_head, cfg_commit, cfg_readback;
  logic       ccff_tail, cfg_done, cfg_err;
  logic [7:0] io_outpad, io_inpad, a2f, f2a, dir;

  int checks = 0;
  int errors = 0;
  logic [31:0] tail_cap;
  logic [15:0] prev_cfg;
  logic [15:0] exp_rb;

  typedef struct {
    logic [15:0] cfg;
    logic [7:0]  outpad;
    logic [7:0]  a2f;
    logic [7:0]  exp_dir;
    logic [7:0]  exp_f2a;
    logic [7:0]  exp_inpad;
  } vec_t;
  vec_t vecs [6];

  grid_io_cfg_tile #(.NUM_IO(8), .CFG_BITS(2)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_en(ccff_en), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .cfg_commit(cfg_commit), .cfg_readback(cfg_readback),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .io_outpad(io_outpad), .io_inpad(io_inpad),
    .gfpga_pad_GPIO_A2F(a2f), .gfpga_pad_GPIO_F2A(f2a), .gfpga_pad_GPIO_DIR(dir)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Shifts w[n-1] first; records ccff_tail before each enabled edge.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      ccff_en   = 1'b1;
      ccff_head = w[k];
      tail_cap  = {tail_cap[30:0], ccff_tail};
      tick();
    end
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    tick();
    tick();
    pReset = 1'b0;
  endtask

  initial begin
    pReset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0; cfg_readback = 1'b0;
    io_outpad = 8'hFF; a2f = 8'hA5; tail_cap = '0;

    //            cfg       outpad  a2f    dir    f2a    inpad
    vecs[0] = '{16'h0000, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'hA5};
    vecs[1] = '{16'h8001, 8'hFF, 8'hA5, 8'h01, 8'h01, 8'h24};
    vecs[2] = '{16'h5555, 8'h3C, 8'hFF, 8'hFF, 8'h3C, 8'h00};
    vecs[3] = '{16'hAAAA, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF0};
    vecs[4] = '{16'hC3A5, 8'hAA, 8'h55, 8'h93, 8'h82, 8'h48};
    vecs[5] = '{16'hC3A5, 8'hFF, 8'hFF, 8'h93, 8'h93, 8'h60};

    // Reset state
    do_reset();
    #1;
    chk("rst_dir", dir, 8'h00);
    chk("rst_f2a", f2a, 8'h00);
    chk("rst_inpad", io_inpad, 8'hA5);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_tail", ccff_tail, 1'b0);

    // Table: load each word, commit, then exercise the pad datapath
    prev_cfg = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      tail_cap = '0;
      shift_bits({16'h0, vecs[i].cfg}, 16);
      chk("tbl_done16", cfg_done, 1'b1);
      chk("tbl_tail", tail_cap[15:0], prev_cfg);
      commit();
      chk("tbl_done_clr", cfg_done, 1'b0);
      io_outpad = vecs[i].outpad;
      a2f       = vecs[i].a2f;
      #1;
      chk("tbl_dir", dir, vecs[i].exp_dir);
      chk("tbl_f2a", f2a, vecs[i].exp_f2a);
      chk("tbl_inpad", io_inpad, vecs[i].exp_inpad);
      chk("tbl_err", cfg_err, 1'b0);
      prev_cfg = vecs[i].cfg;
    end

    // Early commit: rejected, sticky error until reset
    shift_bits(32'h3FF, 10);
    chk("part_done", cfg_done, 1'b0);
    commit();
    chk("part_dir_kept", dir, 8'h93);
    chk("part_err", cfg_err, 1'b1);
    shift_bits(32'h0, 16);
    commit();
    chk("part_recommit_dir", dir, 8'h00);
    chk("part_err_sticky", cfg_err, 1'b1);
    do_reset();
    #1;
    chk("part_err_rst", cfg_err, 1'b0);

    // Commit coincident with the 16th shift: rejected, count restarts at 1
    shift_bits(32'h5555, 15);
    chk("sim_done15", cfg_done, 1'b0);
    ccff_en = 1'b1; ccff_head = 1'b1; cfg_commit = 1'b1;
    tick();
    ccff_en = 1'b0; cfg_commit = 1'b0;
    chk("sim_err", cfg_err, 1'b1);
    chk("sim_dir", dir, 8'h00);
    chk("sim_done", cfg_done, 1'b0);
    shift_bits(32'h0, 14);
    chk("sim_done_cnt15", cfg_done, 1'b0);
    shift_bits(32'h0, 1);
    chk("sim_done_cnt16", cfg_done, 1'b1);

    // Accepted commit while shifting: act takes pre-edge shadow, shift still happens
    do_reset();
    a2f = 8'hA5;
    shift_bits(32'h5555, 16);
    ccff_en = 1'b1; ccff_head = 1'b0; cfg_commit = 1'b1;
    tick();
    ccff_en = 1'b0; cfg_commit = 1'b0;
    chk("acc_dir", dir, 8'hFF);
    chk("acc_done", cfg_done, 1'b0);
    shift_bits(32'h0, 15);
    chk("acc_done16", cfg_done, 1'b1);
    chk("acc_tail", ccff_tail, 1'b0);
    commit();
    #1;
    chk("acc_inpad", io_inpad, 8'hA5);
    chk("acc_err", cfg_err, 1'b0);

    // Over-shift: 20 bits, last 16 committed, first 4 emerge on the tail
    do_reset();
    tail_cap = '0;
    shift_bits({12'h0, 4'hB, 16'h5555}, 20);
    chk("ovr_done", cfg_done, 1'b1);
    chk("ovr_tail_first4", tail_cap[3:0], 4'hB);
    chk("ovr_tail_zero", tail_cap[19:4], 16'h0);
    commit();
    chk("ovr_dir", dir, 8'hFF);

    // Readback (suppresses a coincident shift when enabled)
    do_reset();
    shift_bits({16'h0, 16'hC3A5}, 16);
    commit();
    shift_bits({16'h0, 16'h1234}, 16);
    chk("rb_pre_done", cfg_done, 1'b1);
    cfg_readback = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1;
    tick();
    cfg_readback = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
`ifdef GRID_IO_CFG_READBACK_EN
    exp_rb = 16'hC3A5;
    chk("rb_done", cfg_done, 1'b0);
`else
    exp_rb = 16'h2469;
    chk("rb_done", cfg_done, 1'b1);
`endif
    chk("rb_dir", dir, 8'h93);
    tail_cap = '0;
    shift_bits(32'h0, 16);
    chk("rb_tail", tail_cap[15:0], exp_rb);
    chk("rb_done16", cfg_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
